// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU MEM stage and a DMA master,
// with fixed CPU priority, a DMA anti-starvation counter and an access timeout.
module dmem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int DMA_MAX_WAIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [AW-1:0]   cpu_addr,
   input  logic [DW/8-1:0] cpu_be,
   input  logic [DW-1:0]   cpu_wd,
   output logic            cpu_stall,
   output logic            cpu_rvalid,
   output logic [DW-1:0]   cpu_rdata,
   output logic            cpu_err,
   input  logic            dma_req,
   input  logic            dma_we,
   input  logic [AW-1:0]   dma_addr,
   input  logic [DW/8-1:0] dma_be,
   input  logic [DW-1:0]   dma_wd,
   output logic            dma_done,
   output logic [DW-1:0]   dma_rdata,
   output logic            dma_err,
   output logic            mem_cs,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW/8-1:0] mem_be,
   output logic [DW-1:0]   mem_wd,
   input  logic [DW-1:0]   mem_rd,
   input  logic            mem_ready
);
   localparam int WW = $clog2(DMA_MAX_WAIT + 1);
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CPU_ACC = 2'd1;
   localparam logic [1:0] DMA_ACC = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW/8-1:0] mem_be_q, mem_be_d;
   logic [DW-1:0]   mem_wd_q, mem_wd_d;
   logic            cpu_done_q, cpu_done_d, cpu_rvalid_q, cpu_rvalid_d, cpu_err_q, cpu_err_d;
   logic            dma_done_q, dma_done_d, dma_err_q, dma_err_d;
   logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
   logic            idle, grant_ok, gnt_dma, gnt_cpu, done, tmo, on_cpu, max_wait;

   always_comb begin
      idle         = state_q == IDLE;
      on_cpu       = state_q == CPU_ACC;
      max_wait     = wait_q == WW'(DMA_MAX_WAIT);
      // the cycle a completion pulse is shown, the requesters still present the finished access
      grant_ok     = idle && !(cpu_done_q || dma_done_q || dma_err_q);
      gnt_dma      = grant_ok && dma_req && (!cpu_req || max_wait);
      gnt_cpu      = grant_ok && cpu_req && !gnt_dma;
      done         = !idle && mem_ready;
      tmo          = !idle && !mem_ready && TIMEOUT != 0 && tmo_q == TW'(TIMEOUT - 1);
      state_d      = state_q;
      tmo_d        = idle ? tmo_q : (mem_ready ? tmo_q : tmo_q + 1'b1);
      mem_cs_d     = mem_cs_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wd_d     = mem_wd_q;
      cpu_done_d   = 1'b0;
      cpu_rvalid_d = 1'b0;
      cpu_err_d    = 1'b0;
      dma_done_d   = 1'b0;
      dma_err_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      wait_d       = (gnt_dma || (idle && !dma_req)) ? '0 :
                     (gnt_cpu && dma_req && !max_wait) ? wait_q + 1'b1 : wait_q;
      if (gnt_dma || gnt_cpu) begin
         state_d    = gnt_dma ? DMA_ACC : CPU_ACC;
         tmo_d      = '0;
         mem_cs_d   = 1'b1;
         mem_we_d   = gnt_dma ? dma_we : cpu_we;
         mem_addr_d = (gnt_dma ? dma_addr : cpu_addr) & ~AW'(3);
         mem_be_d   = mem_we_d ? (gnt_dma ? dma_be : cpu_be) : '1;
         mem_wd_d   = gnt_dma ? dma_wd : cpu_wd;
      end
      if (done || tmo) begin
         state_d      = IDLE;
         mem_cs_d     = 1'b0;
         mem_we_d     = 1'b0;
         cpu_done_d   = on_cpu;
         cpu_rvalid_d = on_cpu && done && !mem_we_q;
         cpu_err_d    = on_cpu && tmo;
         dma_done_d   = !on_cpu && done;
         dma_err_d    = !on_cpu && tmo;
         cpu_rdata_d  = !on_cpu ? cpu_rdata_q : tmo ? '0 : mem_we_q ? cpu_rdata_q : mem_rd;
         dma_rdata_d  = on_cpu ? dma_rdata_q : tmo ? '0 : mem_we_q ? dma_rdata_q : mem_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wait_q       <= '0;
         tmo_q        <= '0;
         mem_cs_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wd_q     <= '0;
         cpu_done_q   <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         cpu_err_q    <= 1'b0;
         dma_done_q   <= 1'b0;
         dma_err_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         tmo_q        <= tmo_d;
         mem_cs_q     <= mem_cs_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wd_q     <= mem_wd_d;
         cpu_done_q   <= cpu_done_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_err_q    <= cpu_err_d;
         dma_done_q   <= dma_done_d;
         dma_err_q    <= dma_err_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   assign cpu_stall  = cpu_req && !(idle && cpu_done_q);
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_err    = cpu_err_q;
   assign dma_done   = dma_done_q;
   assign dma_rdata  = dma_rdata_q;
   assign dma_err    = dma_err_q;
   assign mem_cs     = mem_cs_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wd     = mem_wd_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized and directed checks of dmem_port_arbiter against a
// transaction-level model of grants, memory latency and completion results.
module tb_dmem_port_arbiter;
   localparam int TMO  = 16;
   localparam int MAXW = 4;

   logic        clk = 1'b0, reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wd = '0, dma_addr = '0, dma_wd = '0;
   logic [3:0]  cpu_be = '0, dma_be = '0;
   logic        cpu_stall, cpu_rvalid, cpu_err, dma_done, dma_err;
   logic [31:0] cpu_rdata, dma_rdata;
   logic        mem_cs, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic [3:0]  mem_be;

   int          checks = 0, errors = 0;
   int          lat_cfg = 0, cs_cnt = 0;
   bit          force_rdy = 1'b0;
   logic [31:0] rd_cfg = '0, m_cpu_rd = '0, m_dma_rd = '0;

   dmem_port_arbiter #(.AW(32), .DW(32), .DMA_MAX_WAIT(MAXW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be), .cpu_wd(cpu_wd),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_be(dma_be), .dma_wd(dma_wd),
      .dma_done(dma_done), .dma_rdata(dma_rdata), .dma_err(dma_err),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wd(mem_wd),
      .mem_rd(mem_rd), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // memory model: ready after lat_cfg wait cycles of mem_cs; lat_cfg < 0 means never
   always @(posedge clk) cs_cnt <= (mem_cs && !mem_ready) ? cs_cnt + 1 : 0;
   assign mem_ready = force_rdy || (mem_cs && lat_cfg >= 0 && cs_cnt == lat_cfg);
   assign mem_rd    = rd_cfg;

   task automatic run_acc(input bit dma, input bit we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int lat, input logic [31:0] rd);
      logic [31:0] ea, erd, grd;
      logic [3:0]  eb;
      bit          eerr, fin, gok, gerr, eok;
      int          ecs, cs_n, st_n;
      ea   = addr & 32'hFFFF_FFFC;
      eb   = we ? be : 4'hF;
      eerr = lat < 0 || lat >= TMO;
      ecs  = eerr ? TMO : lat + 1;
      erd  = eerr ? 32'h0 : we ? (dma ? m_dma_rd : m_cpu_rd) : rd;
      eok  = !eerr && (dma || !we);
      @(negedge clk);
      lat_cfg = lat;
      rd_cfg  = rd;
      if (dma) begin
         dma_req = 1; dma_we = we; dma_addr = addr; dma_be = be; dma_wd = wd;
      end else begin
         cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wd = wd;
      end
      cs_n = 0; st_n = 0; fin = 0;
      for (int c = 0; c < 100 && !fin; c++) begin
         #1;
         if (!dma && cpu_stall) st_n++;
         if (mem_cs) begin
            cs_n++;
            checks++;
            if (mem_addr !== ea || mem_be !== eb || mem_we !== we || (we && mem_wd !== wd)) begin
               errors++;
               $display("FAIL mem_fields: addr=%h be=%b we=%b wd=%h, required addr=%h be=%b we=%b wd=%h",
                        mem_addr, mem_be, mem_we, mem_wd, ea, eb, we, wd);
            end
         end
         if (dma ? (dma_done || dma_err) : !cpu_stall) begin
            fin  = 1;
            gok  = dma ? dma_done : cpu_rvalid;
            gerr = dma ? dma_err : cpu_err;
            grd  = dma ? dma_rdata : cpu_rdata;
            checks++;
            if (gok !== eok || gerr !== eerr || grd !== erd) begin
               errors++;
               $display("FAIL completion(dma=%0d lat=%0d): ok=%b err=%b rdata=%h, required ok=%b err=%b rdata=%h",
                        dma, lat, gok, gerr, grd, eok, eerr, erd);
            end
         end
         @(negedge clk);
      end
      cpu_req = 0; dma_req = 0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL acc_timeout: no completion within 100 cycles, required one");
      end
      checks++;
      if (cs_n !== ecs || (!dma && st_n !== ecs + 1)) begin
         errors++;
         $display("FAIL cycle_counts: cs=%0d stall=%0d, required cs=%0d stall=%0d", cs_n, st_n, ecs, dma ? 0 : ecs + 1);
      end
      #1;
      checks++;
      if (cpu_rvalid || cpu_err || dma_done || dma_err || mem_cs) begin
         errors++;
         $display("FAIL pulse_width: rvalid=%b cerr=%b done=%b derr=%b cs=%b after completion, required all 0",
                  cpu_rvalid, cpu_err, dma_done, dma_err, mem_cs);
      end
      if (dma) m_dma_rd = erd; else m_cpu_rd = erd;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (mem_cs !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_be !== 0 || mem_wd !== 0 ||
          cpu_rvalid !== 0 || cpu_err !== 0 || dma_done !== 0 || dma_err !== 0 ||
          cpu_rdata !== 0 || dma_rdata !== 0 || cpu_stall !== 0) begin
         errors++;
         $display("FAIL reset_state: cs=%b we=%b addr=%h be=%b stall=%b, required all 0", mem_cs, mem_we, mem_addr, mem_be, cpu_stall);
      end
      cpu_req = 1;
      #1;
      checks++;
      if (cpu_stall !== 1) begin
         errors++;
         $display("FAIL reset_stall: stall=%b, required 1 with cpu_req=1", cpu_stall);
      end
      @(negedge clk);
      cpu_req = 0; reset = 0; force_rdy = 1;
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++;
         if (mem_cs || cpu_rvalid || cpu_err || dma_done || dma_err) begin
            errors++;
            $display("FAIL idle_ready: cs=%b pulses=%b%b%b%b, required 0 when mem_ready in IDLE", mem_cs, cpu_rvalid, cpu_err, dma_done, dma_err);
         end
      end
      force_rdy = 0;
   endtask

   task automatic test_cpu_store();  run_acc(0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 32'h0); endtask
   task automatic test_cpu_load();   run_acc(0, 0, 32'h104, 4'b0000, 32'h0, 3, 32'h12345678); endtask
   task automatic test_dma_sb();     run_acc(1, 1, 32'h203, 4'b1000, 32'hAB000000, 1, 32'h0); endtask
   task automatic test_timeout();    run_acc(0, 0, 32'h108, 4'b0000, 32'h0, -1, 32'h55AA55AA); endtask
   task automatic test_ready_at_limit(); run_acc(1, 0, 32'h30C, 4'b0000, 32'h0, TMO - 1, 32'hC0FFEE01); endtask

   task automatic test_priority();
      int w, n, exp_g, got_g;
      bit prev_cs;
      w = 0; n = 0; prev_cs = 0;
      @(negedge clk);
      lat_cfg = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1000;
      dma_req = 1; dma_we = 0; dma_addr = 32'h2000;
      for (int c = 0; c < 200 && n < 15; c++) begin
         #1;
         if (mem_cs && !prev_cs) begin
            exp_g = (w == MAXW) ? 1 : 0;
            w     = exp_g ? 0 : w + 1;
            got_g = (mem_addr == 32'h2000) ? 1 : 0;
            checks++;
            if (got_g !== exp_g) begin
               errors++;
               $display("FAIL grant_order[%0d]: grant=%s, required %s", n, got_g ? "DMA" : "CPU", exp_g ? "DMA" : "CPU");
            end
            n++;
         end
         prev_cs = mem_cs;
         @(negedge clk);
      end
      cpu_req = 0; dma_req = 0;
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL grant_count: %0d grants, required 15", n);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit bad;
      @(negedge clk);
      lat_cfg = -1;
      dma_req = 1; dma_we = 0; dma_addr = 32'h400;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (mem_cs !== 1) begin
         errors++;
         $display("FAIL mid_active: cs=%b, required 1 during DMA access", mem_cs);
      end
      reset = 1;
      @(negedge clk);
      #1;
      checks++;
      if (mem_cs !== 0 || dma_done !== 0 || dma_err !== 0) begin
         errors++;
         $display("FAIL mid_reset: cs=%b done=%b err=%b, required 0", mem_cs, dma_done, dma_err);
      end
      reset = 0; dma_req = 0;
      m_cpu_rd = 0; m_dma_rd = 0;
      bad = 0;
      repeat (TMO + 8) begin
         @(negedge clk);
         #1;
         if (dma_done || dma_err || mem_cs) bad = 1;
      end
      checks++;
      if (bad || dma_rdata !== 0) begin
         errors++;
         $display("FAIL mid_discard: late activity=%b rdata=%h, required 0 and 0", bad, dma_rdata);
      end
   endtask

   task automatic test_random();
      int r, lat;
      for (int i = 0; i < 40; i++) begin
         r   = $urandom_range(0, 9);
         lat = r == 0 ? -1 : r == 1 ? TMO - 1 : r == 2 ? TMO : $urandom_range(0, 5);
         run_acc(1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom, lat, $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_store();
      test_cpu_load();
      test_dma_sb();
      test_timeout();
      test_ready_at_limit();
      test_reset_mid();
      test_priority();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
